// File: rtl/clkgen_pkg.sv
// Shared constants and helpers for the clock-enable emulation of the SoC clocking front end.
package clkgen_pkg;

    localparam int RESET_LENGTH_DEF = 12;
    localparam int GFCM_TAP_DEF     = 2;
    localparam int FAST_CNT_W       = 3;

    // HF divider select: ratio = 1 << sel (1, 2, 4, 8)
    function automatic int div_ratio(input logic [1:0] sel);
        return 1 << sel;
    endfunction

    function automatic int slow_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clkgen_tick_div.sv
// Modulo-N enable divider: emits a registered one-cycle pulse on each wrap of its counter.
module tick_div #(
    parameter int N = 2,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic hold,
    output logic pulse
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt;
    logic         step;
    logic         wrap;

    assign step = en & ~hold;
    assign wrap = (cnt == LAST);

    // A stalled counter keeps its value so counting resumes where it stopped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= step & wrap;
            if (step) begin
                cnt <= wrap ? '0 : cnt + W'(1);
            end
        end
    end

endmodule

// File: rtl/clkgen_tick_emu.sv
// Single-clock emulation of the HF oscillator, PLL core A/B outputs, LF oscillator and
// power-up reset sequencer, expressed as clock-enable strobes on i_clk.
module clkgen_tick_emu
    import clkgen_pkg::*;
#(
    parameter logic [1:0] HFOSC_DIV    = 2'b01,
    parameter bit         DOUBLE_CLOCK = 1'b0,
    parameter int         SLOW_DIV     = 1000,
    parameter int         RESET_LENGTH = RESET_LENGTH_DEF,
    parameter int         GFCM_TAP     = GFCM_TAP_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic bypass,
    input  logic low_power_mode,
    output logic o_clk_en,
    output logic o_half_clk_en,
    output logic o_slow_tick,
    output logic o_rst,
    output logic o_rst_gfcm
);

    localparam int DIV    = div_ratio(HFOSC_DIV);
    localparam int SLOW_W = slow_cnt_w(SLOW_DIV);

    logic                    div_pulse;
    logic                    byp_q;
    logic                    byp_val_q;
    logic [RESET_LENGTH-1:0] sr;

    tick_div #(
        .N (DIV),
        .W (FAST_CNT_W)
    ) u_fast (
        .clk   (i_clk),
        .rst   (i_rst),
        .en    (low_power_mode),
        .hold  (bypass),
        .pulse (div_pulse)
    );

    // LF oscillator is always on: neither bypass nor low_power_mode touch it.
    tick_div #(
        .N (SLOW_DIV),
        .W (SLOW_W)
    ) u_slow (
        .clk   (i_clk),
        .rst   (i_rst),
        .en    (1'b1),
        .hold  (1'b0),
        .pulse (o_slow_tick)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            byp_q     <= 1'b0;
            byp_val_q <= 1'b0;
        end else begin
            byp_q     <= bypass;
            byp_val_q <= low_power_mode;
        end
    end

    // Both legs are flop outputs; the divider is held whenever bypass was sampled.
    assign o_clk_en = byp_q ? byp_val_q : div_pulse;

    generate
        if (DOUBLE_CLOCK) begin : g_half
            logic tog_q;

            // tog_q counts fast pulses already issued; every second one is passed through.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    tog_q <= 1'b0;
                end else begin
                    tog_q <= tog_q ^ o_clk_en;
                end
            end

            assign o_half_clk_en = o_clk_en & tog_q;
        end else begin : g_same
            assign o_half_clk_en = o_clk_en;
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sr <= '0;
        end else if (o_half_clk_en) begin
            sr <= {sr[RESET_LENGTH-2:0], 1'b1};
        end
    end

    assign o_rst_gfcm = ~sr[GFCM_TAP];
    assign o_rst      = ~sr[RESET_LENGTH-1];

endmodule

// File: tb/tb_clkgen_tick_emu.sv
// Directed bench for clkgen_tick_emu across three parameter sets sharing clock, reset and controls.
module tb_clkgen_tick_emu;

    logic i_clk          = 1'b0;
    logic i_rst          = 1'b0;
    logic bypass         = 1'b0;
    logic low_power_mode = 1'b1;

    logic a_clk_en, a_half, a_slow, a_rst, a_gfcm;
    logic b_clk_en, b_half, b_slow, b_rst, b_gfcm;
    logic c_clk_en, c_half, c_slow, c_rst, c_gfcm;

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    // A: defaults (DIV=2, single rate, SLOW_DIV=1000)
    clkgen_tick_emu #(
        .HFOSC_DIV    (2'b01),
        .DOUBLE_CLOCK (1'b0),
        .SLOW_DIV     (1000),
        .RESET_LENGTH (12),
        .GFCM_TAP     (2)
    ) dut_a (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .bypass         (bypass),
        .low_power_mode (low_power_mode),
        .o_clk_en       (a_clk_en),
        .o_half_clk_en  (a_half),
        .o_slow_tick    (a_slow),
        .o_rst          (a_rst),
        .o_rst_gfcm     (a_gfcm)
    );

    // B: DIV=1, half rate on core B
    clkgen_tick_emu #(
        .HFOSC_DIV    (2'b00),
        .DOUBLE_CLOCK (1'b1),
        .SLOW_DIV     (1000),
        .RESET_LENGTH (12),
        .GFCM_TAP     (2)
    ) dut_b (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .bypass         (bypass),
        .low_power_mode (low_power_mode),
        .o_clk_en       (b_clk_en),
        .o_half_clk_en  (b_half),
        .o_slow_tick    (b_slow),
        .o_rst          (b_rst),
        .o_rst_gfcm     (b_gfcm)
    );

    // C: DIV=8, SLOW_DIV=10
    clkgen_tick_emu #(
        .HFOSC_DIV    (2'b11),
        .DOUBLE_CLOCK (1'b0),
        .SLOW_DIV     (10),
        .RESET_LENGTH (12),
        .GFCM_TAP     (2)
    ) dut_c (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .bypass         (bypass),
        .low_power_mode (low_power_mode),
        .o_clk_en       (c_clk_en),
        .o_half_clk_en  (c_half),
        .o_slow_tick    (c_slow),
        .o_rst          (c_rst),
        .o_rst_gfcm     (c_gfcm)
    );

    task automatic chk(input string tag, input int k, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Releases reset 1 time unit after an edge, so the next edge is k=1.
    task automatic do_reset();
        i_rst = 1'b1;
        step();
        step();
        i_rst = 1'b0;
    endtask

    task automatic run_ab(input int n);
        for (int k = 1; k <= n; k++) begin
            step();
            chk("a_clk_en", k, a_clk_en, (k % 2) == 0);
            chk("a_half",   k, a_half,   (k % 2) == 0);
            chk("a_gfcm",   k, a_gfcm,   k < 7);
            chk("a_rst",    k, a_rst,    k < 25);
            chk("a_slow",   k, a_slow,   1'b0);
            chk("b_clk_en", k, b_clk_en, 1'b1);
            chk("b_half",   k, b_half,   (k % 2) == 0);
            chk("b_gfcm",   k, b_gfcm,   k < 7);
            chk("b_rst",    k, b_rst,    k < 25);
        end
    endtask

    initial begin
        // asynchronous reset state, no clock edge involved
        #2;
        i_rst = 1'b1;
        #1;
        chk("rst_a_clk_en", 0, a_clk_en, 1'b0);
        chk("rst_a_half",   0, a_half,   1'b0);
        chk("rst_a_slow",   0, a_slow,   1'b0);
        chk("rst_a_rst",    0, a_rst,    1'b1);
        chk("rst_a_gfcm",   0, a_gfcm,   1'b1);
        chk("rst_c_slow",   0, c_slow,   1'b0);

        // defaults, continuous enable
        bypass         = 1'b0;
        low_power_mode = 1'b1;
        do_reset();
        run_ab(30);

        // reset asserted between edges after edge 15, then the sequence must repeat
        do_reset();
        run_ab(15);
        #2;
        i_rst = 1'b1;
        #1;
        chk("mid_a_rst",    15, a_rst,    1'b1);
        chk("mid_a_gfcm",   15, a_gfcm,   1'b1);
        chk("mid_a_clk_en", 15, a_clk_en, 1'b0);
        chk("mid_a_half",   15, a_half,   1'b0);
        chk("mid_b_clk_en", 15, b_clk_en, 1'b0);
        chk("mid_b_rst",    15, b_rst,    1'b1);
        chk("mid_b_gfcm",   15, b_gfcm,   1'b1);
        step();
        i_rst = 1'b0;
        run_ab(30);

        // DIV=8 with low_power_mode low on edges 11..15; counter holds at 2
        bypass         = 1'b0;
        low_power_mode = 1'b1;
        do_reset();
        for (int k = 1; k <= 30; k++) begin
            if (k == 11) low_power_mode = 1'b0;
            if (k == 16) low_power_mode = 1'b1;
            step();
            chk("lp_c_clk_en", k, c_clk_en, (k == 8) || (k == 21) || (k == 29));
            chk("lp_c_half",   k, c_half,   (k == 8) || (k == 21) || (k == 29));
            chk("lp_c_slow",   k, c_slow,   (k % 10) == 0);
        end

        // bypass with DIV=8, then stop HF, then leave bypass from held count 0
        bypass         = 1'b1;
        low_power_mode = 1'b1;
        do_reset();
        for (int k = 1; k <= 44; k++) begin
            if (k == 6) low_power_mode = 1'b0;
            if (k == 36) begin
                bypass         = 1'b0;
                low_power_mode = 1'b1;
            end
            step();
            chk("byp_c_clk_en", k, c_clk_en, (k <= 5) || (k == 43));
            chk("byp_c_slow",   k, c_slow,   (k % 10) == 0);
            chk("byp_c_rst",    k, c_rst,    1'b1);
            if (k <= 8) chk("byp_c_gfcm", k, c_gfcm, k < 4);
        end

        // HF stopped from release: resets stay asserted, LF keeps ticking
        bypass         = 1'b0;
        low_power_mode = 1'b0;
        do_reset();
        for (int k = 1; k <= 50; k++) begin
            step();
            chk("stop_a_rst",    k, a_rst,    1'b1);
            chk("stop_a_gfcm",   k, a_gfcm,   1'b1);
            chk("stop_a_clk_en", k, a_clk_en, 1'b0);
            chk("stop_b_clk_en", k, b_clk_en, 1'b0);
            chk("stop_b_gfcm",   k, b_gfcm,   1'b1);
            chk("stop_c_rst",    k, c_rst,    1'b1);
            chk("stop_c_gfcm",   k, c_gfcm,   1'b1);
            chk("stop_c_slow",   k, c_slow,   (k % 10) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clkgen_tick_emu.md
Name: clkgen_tick_emu

Overview:
- Synthesizable single-clock emulation of the SoC clocking front end: the internal HF oscillator, the PLL with its core-A and half-rate core-B outputs, the always-on LF oscillator, and the power-up reset sequencer.
- Instead of generating clocks, it produces one-cycle clock-enable strobes derived from i_clk.
- Sits between the board reference clock and the servant core, timer and GFCM logic, which consume the strobes and the two reset outputs.

Parameters:
- HFOSC_DIV, 2'b01: HF divide select; divide ratio DIV = 1<<HFOSC_DIV, so 00=1, 01=2, 10=4, 11=8.
- DOUBLE_CLOCK, 0: 1 makes o_half_clk_en half the rate of o_clk_en; 0 makes them identical.
- SLOW_DIV, 1000: i_clk cycles per o_slow_tick, LF oscillator emulation; must be >= 2.
- RESET_LENGTH, 12: length of the reset shift register; must be >= 4.
- GFCM_TAP, 2: shift-register bit that releases o_rst_gfcm; must be < RESET_LENGTH-1.

Ports:
- i_clk, in, 1: the single clock.
- i_rst, in, 1: asynchronous active-high reset.
- bypass, in, 1: PLL/divider bypass.
- low_power_mode, in, 1: HF enable; 1 = running, 0 = stopped and latched.
- o_clk_en, out, 1: fast strobe, PLL core A / HFOSC.
- o_half_clk_en, out, 1: half-rate strobe, PLL core B.
- o_slow_tick, out, 1: LF oscillator strobe.
- o_rst, out, 1: system reset, active high.
- o_rst_gfcm, out, 1: early reset for the glitch-free clock mux, active high.

Behaviour:
- All outputs are registered. While i_rst=1 (asynchronous):
  - counters = 0, half toggle = 0, shift register = 0;
  - o_clk_en = o_half_clk_en = o_slow_tick = 0;
  - o_rst = o_rst_gfcm = 1.
- Edge numbering: k=1 is the first rising edge of i_clk after i_rst deasserts.
- Fast divider:
  - 3-bit counter. It advances only on edges where low_power_mode=1 and wraps at DIV-1.
  - o_clk_en is 1 after the edge on which the counter wraps. With continuous enable, it is high after edge k iff k mod DIV == 0; DIV=1 gives high every cycle.
  - low_power_mode=0: counter holds its value (LATCHINPUTVALUE semantics) and o_clk_en=0 on the next edge. Counting resumes from the held value.
  - bypass=1: o_clk_en = low_power_mode, registered, on every edge; the counter holds. Clearing bypass resumes the divider from the held count.
- Half strobe:
  - DOUBLE_CLOCK=0: o_half_clk_en is identical to o_clk_en, same edge.
  - DOUBLE_CLOCK=1: the toggle flips on each edge where the fast pulse is generated; o_half_clk_en asserts with every second fast pulse, namely the 2nd, 4th, and so on after reset.
- Slow tick:
  - Free-running counter that ignores low_power_mode and bypass (LF oscillator always enabled).
  - o_slow_tick is high after edge k iff k mod SLOW_DIV == 0.
- Reset sequencer:
  - On each edge where the registered o_half_clk_en is 1, shift {sr[RESET_LENGTH-2:0],1'b1}.
  - o_rst_gfcm = ~sr[GFCM_TAP]; o_rst = ~sr[RESET_LENGTH-1]. Both are derived combinationally from sr.
  - Therefore o_rst_gfcm falls after the (GFCM_TAP+1)th sampled half strobe, and o_rst after the RESET_LENGTHth.
  - If strobes stop (low_power_mode=0), the sequence pauses and resets stay asserted.
  - Once fully set, sr stays all-ones until i_rst.
- Reset asserted mid-sequence clears sr immediately and both resets reassert asynchronously.
- Simultaneous bypass and low_power_mode changes on one edge: bypass decides the path, low_power_mode decides the value.

Decomposition:
- Package clkgen_pkg:
  - divide-ratio decode function (2-bit select to ratio);
  - RESET_LENGTH and GFCM_TAP defaults;
  - width helper for the slow counter (clog2 of SLOW_DIV).
- One reusable sub-module, tick_div (parameter N, inputs en and hold, output registered pulse), instantiated for the fast and slow strobes.

Test Plan:
- Defaults (DIV=2, DOUBLE_CLOCK=0), low_power_mode=1, bypass=0; release reset:
  - o_clk_en and o_half_clk_en high after edges 2,4,6,…;
  - o_rst_gfcm falls after edge 7;
  - o_rst falls after edge 25.
- HFOSC_DIV=2'b00, DOUBLE_CLOCK=1:
  - o_clk_en high every cycle from edge 1;
  - o_half_clk_en high after edges 2,4,…;
  - o_rst_gfcm falls after edge 7.
- HFOSC_DIV=2'b11: o_clk_en high after edges 8,16; at edge 10 drive low_power_mode=0 for 5 edges:
  - no strobes while low;
  - counter held at 2;
  - next pulse 6 enabled edges after re-enable.
- bypass=1 with DIV=8: o_clk_en=1 every cycle. Then low_power_mode=0: o_clk_en=0 on the next edge, while o_slow_tick (SLOW_DIV=10) continues after edges 10,20,30.
- Assert i_rst asynchronously mid-sequence, after edge 15 in test 1:
  - o_rst and o_rst_gfcm go high without a clock edge;
  - all strobes 0;
  - after release, the sequence from test 1 repeats exactly.
- low_power_mode=0 from reset release for 50 edges: o_rst and o_rst_gfcm remain 1 and o_slow_tick still pulses.
